// File: rtl/layer_compositor.sv
// Fixed-priority N-layer pixel compositor with frame-synchronous layer masks and frame-counted blink.
// Latency 2 clocks at 1 pixel/clock; free-running pixel stream, no backpressure.
module layer_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int CW           = 8,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   pixelx,
  input  logic [9:0]                   pixely,
  input  logic [NUM_LAYERS-1:0]        layer_visible,
  input  logic [NUM_LAYERS*3*CW-1:0]   layer_color,
  input  logic [NUM_LAYERS-1:0]        layer_mask,
  input  logic [NUM_LAYERS-1:0]        layer_blink,
  input  logic [3*CW-1:0]              bg_color,
  output logic [CW-1:0]                vga_r,
  output logic [CW-1:0]                vga_g,
  output logic [CW-1:0]                vga_b,
  output logic                         blank,
  output logic                         sync,
  output logic                         frame_start,
  output logic                         blink_phase
);

  localparam int PW = 3 * CW;
  localparam int SW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);

  logic [9:0]            prev_x;
  logic [9:0]            prev_y;
  logic [NUM_LAYERS-1:0] mask_shadow;
  logic [BW-1:0]         blink_cnt;

  logic                  active;
  logic                  fs;
  logic                  wrap;
  logic                  eff_phase;
  logic [NUM_LAYERS-1:0] eff_mask;
  logic [NUM_LAYERS-1:0] qual;
  logic                  hit_d;
  logic [SW-1:0]         sel_d;
  logic [PW-1:0]         col_d;

  logic                  s1_active;
  logic                  s1_fs;
  logic                  s1_hit;
  logic [SW-1:0]         s1_sel;
  logic [PW-1:0]         s1_col;
  logic [PW-1:0]         s1_bg;
  logic [PW-1:0]         out_col;

  assign sync = 1'b1;

  always_comb begin
    active    = ({1'b0, pixely} < VA) && ({1'b0, pixelx} < HA);
    fs        = (pixelx == 10'd0) && (pixely == 10'd0) &&
                ((prev_x != 10'd0) || (prev_y != 10'd0));
    wrap      = (blink_cnt == BW'(BLINK_FRAMES - 1));
    // A frame-start pixel already sees the new mask and the toggled phase.
    eff_mask  = fs ? layer_mask : mask_shadow;
    eff_phase = (fs && wrap) ? ~blink_phase : blink_phase;
    qual      = layer_visible & eff_mask & (~layer_blink | {NUM_LAYERS{eff_phase}});
    hit_d     = |qual;
    sel_d     = '0;
    col_d     = '0;
    // Scan from the top so the lowest qualifying index is the last one written.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (qual[i]) begin
        sel_d = SW'(i);
        col_d = layer_color[i*PW +: PW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_x      <= '0;
      prev_y      <= '0;
      mask_shadow <= '1;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      prev_x <= pixelx;
      prev_y <= pixely;
      if (fs) begin
        mask_shadow <= layer_mask;
        if (wrap) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_active <= 1'b0;
      s1_fs     <= 1'b0;
      s1_hit    <= 1'b0;
      s1_sel    <= '0;
      s1_col    <= '0;
      s1_bg     <= '0;
    end else begin
      s1_active <= active;
      s1_fs     <= fs;
      s1_hit    <= hit_d;
      s1_sel    <= sel_d;
      s1_col    <= col_d;
      s1_bg     <= bg_color;
    end
  end

  always_comb begin
    out_col = '0;
    if (s1_active) out_col = s1_hit ? s1_col : s1_bg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= out_col;
      blank                 <= s1_active;
      frame_start           <= s1_fs;
    end
  end

  sel_idle_zero: assert property (@(posedge clk) disable iff (rst) !s1_hit |-> (s1_sel == '0));

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised and directed stimulus against a frame-level reference model, scored by a decoupled monitor.
module tb_layer_compositor;

  localparam int NL = 4;
  localparam int CW = 8;
  localparam int PW = 3 * CW;
  localparam int BF = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [9:0]        pixelx = '0;
  logic [9:0]        pixely = '0;
  logic [NL-1:0]     layer_visible = '0;
  logic [NL*PW-1:0]  layer_color = '0;
  logic [NL-1:0]     layer_mask = '1;
  logic [NL-1:0]     layer_blink = '0;
  logic [PW-1:0]     bg_color = '0;
  logic [CW-1:0]     vga_r, vga_g, vga_b;
  logic              blank, sync, frame_start, blink_phase;

  layer_compositor #(.NUM_LAYERS(NL), .CW(CW), .H_ACTIVE(640), .V_ACTIVE(480), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .pixelx(pixelx), .pixely(pixely),
    .layer_visible(layer_visible), .layer_color(layer_color),
    .layer_mask(layer_mask), .layer_blink(layer_blink), .bg_color(bg_color),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .blank(blank), .sync(sync), .frame_start(frame_start), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [23:0] col;
    logic        blank;
    logic        fs;
    logic        ph;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nbad = 0;

  // Reference model state: frame-level view of the compositor.
  int          m_px = 0, m_py = 0, m_cnt = 0;
  bit          m_ph = 1'b1;
  logic [NL-1:0] m_shadow = '1;

  logic [NL*PW-1:0] g_cols;
  logic [PW-1:0]    g_bg;
  logic [NL-1:0]    g_mask = '1;
  logic [NL-1:0]    g_blk  = '0;

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] want);
    ncmp++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s at cycle %0d: got %06h want %06h", name, cyc, got, want);
    end
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic [NL-1:0] vis,
                      input logic [NL-1:0] msk, input logic [NL-1:0] blk,
                      input logic [NL*PW-1:0] cols, input logic [PW-1:0] bg, input logic r);
    exp_t e;
    exp_t t;
    bit   f, hit, act;
    logic [23:0] c;
    @(posedge clk); #1;
    pixelx = x; pixely = y; layer_visible = vis; layer_mask = msk;
    layer_blink = blk; layer_color = cols; bg_color = bg; rst = r;
    e.due = cyc + 2;
    if (r) begin
      // The pixel issued one cycle earlier is wiped before it reaches the output.
      if (sb.size() > 0 && sb[$].due == cyc + 1) begin
        t = sb.pop_back();
        t.col = '0; t.blank = 1'b0; t.fs = 1'b0;
        sb.push_back(t);
      end
      e.col = '0; e.blank = 1'b0; e.fs = 1'b0; e.ph = 1'b1;
      m_px = 0; m_py = 0; m_cnt = 0; m_ph = 1'b1; m_shadow = '1;
    end else begin
      act = (int'(x) < 640) && (int'(y) < 480);
      f   = (x == 0) && (y == 0) && !(m_px == 0 && m_py == 0);
      if (f) begin
        m_shadow = msk;
        m_cnt = m_cnt + 1;
        if (m_cnt == BF) begin
          m_cnt = 0;
          m_ph  = !m_ph;
        end
      end
      hit = 1'b0;
      c   = bg;
      for (int i = 0; i < NL; i++)
        if (!hit && vis[i] && m_shadow[i] && (!blk[i] || m_ph)) begin
          hit = 1'b1;
          c   = cols[i*PW +: PW];
        end
      e.col = act ? c : 24'h0;
      e.blank = act;
      e.fs = f;
      e.ph = m_ph;
      m_px = int'(x); m_py = int'(y);
    end
    sb.push_back(e);
  endtask

  task automatic px(input int x, input int y, input logic [NL-1:0] vis);
    step(10'(x), 10'(y), vis, g_mask, g_blk, g_cols, g_bg, 1'b0);
  endtask

  // Monitor: every negedge, score the entries whose output is due now.
  bit prev_ph = 1'b1;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          ncmp++; nbad++;
          $display("FAIL late_entry: due %0d seen at %0d", e.due, cyc);
        end else begin
          chk("colour", {vga_r, vga_g, vga_b}, e.col);
          chk("blank", 24'(blank), 24'(e.blank));
          chk("frame_start", 24'(frame_start), 24'(e.fs));
          chk("blink_phase", 24'(prev_ph), 24'(e.ph));
          chk("sync", 24'(sync), 24'h1);
        end
      end
      prev_ph = blink_phase;
    end
  end

  initial begin
    logic [NL*PW-1:0] rc;
    int rx, ry, sel;
    g_cols = {24'h0000FF, 24'h123456, 24'h00FF00, 24'hFF0000};
    g_bg   = 24'hA5C4D4;

    // Reset held 3 cycles with layer 0 visible, then release.
    repeat (3) step(10'd5, 10'd5, 4'b0001, g_mask, g_blk, g_cols, g_bg, 1'b1);
    repeat (3) px(5, 5, 4'b0001);

    // Priority and no-overlap background.
    px(10, 10, 4'b1010);
    px(10, 11, 4'b0000);
    px(11, 11, 4'b1111);

    // Blanking boundaries.
    px(640, 10, 4'b0001);
    px(639, 479, 4'b0001);
    px(10, 480, 4'b0001);
    px(700, 500, 4'b0000);

    // Frame-synchronous mask, (0,0) held for three cycles.
    px(0, 0, 4'b0001);
    px(1, 0, 4'b0001);
    g_mask = 4'b1110;
    px(2, 0, 4'b0001);
    px(3, 0, 4'b0001);
    repeat (3) px(0, 0, 4'b0001);
    g_mask = 4'b1111;
    px(1, 0, 4'b0001);
    px(2, 0, 4'b0011);
    px(0, 0, 4'b0001);
    px(1, 0, 4'b0001);

    // Reset mid-frame at (100,100), then resume.
    px(99, 100, 4'b0001);
    step(10'd100, 10'd100, 4'b0001, g_mask, g_blk, g_cols, g_bg, 1'b1);
    px(101, 100, 4'b0001);
    px(102, 100, 4'b0010);
    px(103, 100, 4'b0000);

    // Five short frames with layer 0 blinking and layer 1 steady.
    g_blk = 4'b0001;
    for (int f = 0; f < 5; f++) begin
      px(0, 0, 4'b0000);
      px(1, 0, 4'b0001);
      px(2, 0, 4'b0010);
      px(3, 0, 4'b0011);
      px(4, 1, 4'b0001);
    end
    g_blk = '0;

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NL; i++) rc[i*PW +: PW] = 24'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 2) begin rx = 0; ry = 0; end
      else if (sel == 2) begin rx = 639; ry = $urandom_range(470, 481); end
      else if (sel == 3) begin rx = $urandom_range(638, 641); ry = 479; end
      else if (sel == 4) begin rx = $urandom_range(0, 1023); ry = $urandom_range(0, 1023); end
      else begin rx = $urandom_range(0, 700); ry = $urandom_range(0, 520); end
      step(10'(rx), 10'(ry), 4'($urandom), 4'($urandom), 4'($urandom), rc, 24'($urandom),
           ($urandom_range(0, 199) == 0));
    end

    repeat (4) px(20, 20, 4'b0000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      ncmp++; nbad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
